// File: rtl/aludec_mdu.sv
// aludec_mdu: ALU control decoder with a sequential RV M-extension
// multiply/divide unit and a stall handshake to the core pipeline.
//
// Plain ALU operations are decoded combinationally. M operations are
// accepted from IDLE and iterate one bit per cycle (shift-add multiply,
// restoring divide) on operand magnitudes, with signs fixed up at the end.
// Divide-by-zero and signed overflow bypass iteration and go straight to DONE.
//
// Optional feature macro: ALUDEC_MDU_FAST_MUL_EN
//   defined   -> multiplies use one combinational XLEN x XLEN product that is
//                registered at accept (IDLE -> DONE directly).
//   undefined -> iterative shift-add multiply; no multiplier operator is used.
module aludec_mdu #(
    parameter int XLEN     = 32,
    parameter int MD_CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      ALUOp,
    input  logic            opb5,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic            funct7b0,
    input  logic            valid_in,
    input  logic [XLEN-1:0] srca,
    input  logic [XLEN-1:0] srcb,
    output logic [3:0]      ALUControl,
    output logic            md_op,
    output logic            stall,
    output logic            md_done,
    output logic [XLEN-1:0] md_result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    state_t              state_q;
    logic [MD_CNT_W-1:0] cnt_q;
    // Upper half: running product high word / partial remainder.
    // Lower half: multiplier being shifted out / dividend-quotient.
    logic [2*XLEN-1:0]   acc_q;
    logic [XLEN-1:0]     opb_q;      // multiplicand or divisor magnitude
    logic                res_neg_q;  // product / quotient must be negated
    logic                rem_neg_q;  // remainder must be negated
    logic [2:0]          funct3_q;
    logic                md_done_q;
    logic [XLEN-1:0]     md_result_q;

    // ALU control decode; M ops force 0000 so the ALU stays benign.
    always_comb begin
        md_op      = (ALUOp == 2'b10) & opb5 & funct7b0;
        ALUControl = 4'b0000;
        case (ALUOp)
            2'b00: ALUControl = 4'b0000;
            2'b01: ALUControl = 4'b0001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (opb5 & funct7b5) ? 4'b0001 : 4'b0000;
                    3'b001:  ALUControl = 4'b0100;
                    3'b010:  ALUControl = 4'b0101;
                    3'b011:  ALUControl = 4'b0110;
                    3'b100:  ALUControl = 4'b0111;
                    3'b101:  ALUControl = funct7b5 ? 4'b1001 : 4'b1000;
                    3'b110:  ALUControl = 4'b0011;
                    default: ALUControl = 4'b0010;
                endcase
                if (md_op) begin
                    ALUControl = 4'b0000;
                end
            end
            default: ALUControl = 4'b0000;
        endcase
    end

    assign stall     = valid_in & md_op & (state_q != S_DONE);
    assign md_done   = md_done_q;
    assign md_result = md_result_q;

    // Accept-time operand preparation: signedness, magnitudes, special cases.
    logic            acc_is_div;
    logic            a_signed;
    logic            b_signed;
    logic            sign_a;
    logic            sign_b;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_by_zero;
    logic            div_ovf;
    logic [XLEN-1:0] special_result;

    always_comb begin
        acc_is_div     = funct3[2];
        a_signed       = acc_is_div ? ~funct3[0] : (funct3[1] ^ funct3[0]);
        b_signed       = acc_is_div ? ~funct3[0] : (funct3[1:0] == 2'b01);
        sign_a         = a_signed & srca[XLEN-1];
        sign_b         = b_signed & srcb[XLEN-1];
        a_mag          = sign_a ? (~srca + 1'b1) : srca;
        b_mag          = sign_b ? (~srcb + 1'b1) : srcb;
        div_by_zero    = (srcb == '0);
        div_ovf        = ~funct3[0] & (srca == MIN_VAL) & (&srcb);
        special_result = div_by_zero ? (funct3[1] ? srca : {XLEN{1'b1}})
                                     : (funct3[1] ? '0 : MIN_VAL);
    end

`ifdef ALUDEC_MDU_FAST_MUL_EN
    // Single-cycle product of magnitudes, sign applied afterwards.
    logic [2*XLEN-1:0] fast_prod;
    logic [2*XLEN-1:0] fast_signed;
    logic [XLEN-1:0]   fast_result;

    always_comb begin
        fast_prod   = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
        fast_signed = (sign_a ^ sign_b) ? (~fast_prod + 1'b1) : fast_prod;
        fast_result = (funct3[1:0] == 2'b00) ? fast_signed[XLEN-1:0]
                                             : fast_signed[2*XLEN-1:XLEN];
    end
`endif

    // One iteration step of multiply or divide, plus final sign fix-up.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [2*XLEN-1:0] mul_signed;
    logic [XLEN-1:0]   mul_fin;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     rem_diff;
    logic              rem_ge;
    logic [2*XLEN-1:0] div_next;
    logic [XLEN-1:0]   quot_fin;
    logic [XLEN-1:0]   rem_fin;
    logic [XLEN-1:0]   div_fin;
    logic [2*XLEN-1:0] step_next;
    logic [XLEN-1:0]   step_fin;

    always_comb begin
        // Shift-add: conditionally add multiplicand to high word, shift right.
        mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next   = {mul_sum, acc_q[XLEN-1:1]};
        mul_signed = res_neg_q ? (~mul_next + 1'b1) : mul_next;
        mul_fin    = (funct3_q[1:0] == 2'b00) ? mul_signed[XLEN-1:0]
                                              : mul_signed[2*XLEN-1:XLEN];

        // Restoring divide: shift in next dividend bit, subtract if it fits.
        rem_sh     = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        rem_diff   = rem_sh - {1'b0, opb_q};
        rem_ge     = ~rem_diff[XLEN];
        div_next   = {(rem_ge ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0]),
                      acc_q[XLEN-2:0], rem_ge};
        quot_fin   = res_neg_q ? (~div_next[XLEN-1:0] + 1'b1) : div_next[XLEN-1:0];
        rem_fin    = rem_neg_q ? (~div_next[2*XLEN-1:XLEN] + 1'b1)
                               : div_next[2*XLEN-1:XLEN];
        div_fin    = funct3_q[1] ? rem_fin : quot_fin;

        step_next  = funct3_q[2] ? div_next : mul_next;
        step_fin   = funct3_q[2] ? div_fin  : mul_fin;
    end

    // Control FSM with registered done pulse and result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            opb_q       <= '0;
            res_neg_q   <= 1'b0;
            rem_neg_q   <= 1'b0;
            funct3_q    <= '0;
            md_done_q   <= 1'b0;
            md_result_q <= '0;
        end else begin
            md_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (valid_in && md_op) begin
                        funct3_q  <= funct3;
                        cnt_q     <= MD_CNT_W'(XLEN - 1);
                        res_neg_q <= sign_a ^ sign_b;
                        rem_neg_q <= sign_a;
                        if (acc_is_div) begin
                            if (div_by_zero || div_ovf) begin
                                md_result_q <= special_result;
                                md_done_q   <= 1'b1;
                                state_q     <= S_DONE;
                            end else begin
                                acc_q   <= {{XLEN{1'b0}}, a_mag};
                                opb_q   <= b_mag;
                                state_q <= S_DIV;
                            end
                        end else begin
`ifdef ALUDEC_MDU_FAST_MUL_EN
                            md_result_q <= fast_result;
                            md_done_q   <= 1'b1;
                            state_q     <= S_DONE;
`else
                            acc_q   <= {{XLEN{1'b0}}, b_mag};
                            opb_q   <= a_mag;
                            state_q <= S_MUL;
`endif
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    acc_q <= step_next;
                    if (cnt_q == '0) begin
                        md_result_q <= step_fin;
                        md_done_q   <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - MD_CNT_W'(1);
                    end
                end
                default: begin
                    // DONE: never restarts directly; always passes through IDLE.
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aludec_mdu.sv
// Testbench for aludec_mdu: directed and randomized checks of the ALU
// decoder and the multiply/divide unit against a 64-bit arithmetic model.
module tb_aludec_mdu;

    localparam int XLEN = 32;

    logic            clk;
    logic            reset;
    logic [1:0]      ALUOp;
    logic            opb5;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            funct7b0;
    logic            valid_in;
    logic [XLEN-1:0] srca;
    logic [XLEN-1:0] srcb;
    logic [3:0]      ALUControl;
    logic            md_op;
    logic            stall;
    logic            md_done;
    logic [XLEN-1:0] md_result;

    int n_checks = 0;
    int n_fail   = 0;

    aludec_mdu #(.XLEN(XLEN), .MD_CNT_W(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .ALUOp      (ALUOp),
        .opb5       (opb5),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .funct7b0   (funct7b0),
        .valid_in   (valid_in),
        .srca       (srca),
        .srcb       (srcb),
        .ALUControl (ALUControl),
        .md_op      (md_op),
        .stall      (stall),
        .md_done    (md_done),
        .md_result  (md_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference ALU control from the decode table.
    function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic b5,
                                            input logic [2:0] f3, input logic f7b5,
                                            input logic f7b0);
        if (op == 2'b00) return 4'b0000;
        if (op == 2'b01) return 4'b0001;
        if (op == 2'b11) return 4'b0000;
        if (b5 && f7b0) return 4'b0000;
        case (f3)
            3'd0: return (b5 && f7b5) ? 4'b0001 : 4'b0000;
            3'd1: return 4'b0100;
            3'd2: return 4'b0101;
            3'd3: return 4'b0110;
            3'd4: return 4'b0111;
            3'd5: return f7b5 ? 4'b1001 : 4'b1000;
            3'd6: return 4'b0011;
            default: return 4'b0010;
        endcase
    endfunction

    // Reference M-extension result using wide arithmetic.
    function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        logic        ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Expected number of cycles with stall high (acceptance cycle included).
    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
        if (f3[2]) begin
            if (b == 0) return 1;
            if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return XLEN + 1;
        end
`ifdef ALUDEC_MDU_FAST_MUL_EN
        return 1;
`else
        return XLEN + 1;
`endif
    endfunction

    // Issue one M op with valid held until done; optionally keep valid high after.
    task automatic run_md(input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input bit keep);
        int          n;
        bit          early;
        logic [31:0] exp;
        exp      = ref_md(f3, a, b);
        ALUOp    = 2'b10;
        opb5     = 1'b1;
        funct7b0 = 1'b1;
        funct7b5 = 1'b0;
        funct3   = f3;
        srca     = a;
        srcb     = b;
        valid_in = 1'b1;
        #1;
        check("md_op_m", {63'd0, md_op}, 64'd1);
        check("aluctl_m", {60'd0, ALUControl}, 64'd0);
        n     = 0;
        early = 0;
        while (stall === 1'b1 && n < 200) begin
            if (md_done !== 1'b0) early = 1;
            n++;
            @(negedge clk);
            #1;
        end
        check("stall_cycles", 64'(n), 64'(ref_lat(f3, a, b)));
        check("no_early_done", {63'd0, early}, 64'd0);
        check("done_pulse", {63'd0, md_done}, 64'd1);
        check("md_result", {32'd0, md_result}, {32'd0, exp});
        $display("md f3=%0d a=%h b=%h result=%h expected=%h stall_cycles=%0d",
                 f3, a, b, md_result, exp, n);
        if (!keep) valid_in = 1'b0;
        @(negedge clk);
        #1;
        check("done_one_cycle", {63'd0, md_done}, 64'd0);
        check("result_hold", {32'd0, md_result}, {32'd0, exp});
        if (keep) check("reaccept_stall", {63'd0, stall}, 64'd1);
    endtask

    initial begin
        int          n;
        logic [2:0]  f3;
        logic [31:0] a, b;
        logic [31:0] exp;

        reset    = 1'b1;
        ALUOp    = 2'b00;
        opb5     = 1'b0;
        funct3   = 3'd0;
        funct7b5 = 1'b0;
        funct7b0 = 1'b0;
        valid_in = 1'b0;
        srca     = '0;
        srcb     = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_done", {63'd0, md_done}, 64'd0);
        check("rst_result", {32'd0, md_result}, 64'd0);
        check("rst_stall", {63'd0, stall}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed decode: sra with valid high must not stall.
        ALUOp = 2'b10; funct3 = 3'b101; funct7b5 = 1'b1; opb5 = 1'b1; funct7b0 = 1'b0;
        valid_in = 1'b1;
        #1;
        check("dec_sra", {60'd0, ALUControl}, 64'b1001);
        check("dec_sra_mdop", {63'd0, md_op}, 64'd0);
        check("dec_sra_stall", {63'd0, stall}, 64'd0);
        ALUOp = 2'b11;
        #1;
        check("dec_rsvd", {60'd0, ALUControl}, 64'd0);
        valid_in = 1'b0;
        @(negedge clk);

        // Randomized decode sweep with valid low.
        for (int i = 0; i < 40; i++) begin
            ALUOp    = 2'($urandom_range(0, 3));
            opb5     = 1'($urandom_range(0, 1));
            funct3   = 3'($urandom_range(0, 7));
            funct7b5 = 1'($urandom_range(0, 1));
            funct7b0 = 1'($urandom_range(0, 1));
            #1;
            check("dec_rand", {60'd0, ALUControl},
                  {60'd0, ref_ctrl(ALUOp, opb5, funct3, funct7b5, funct7b0)});
            check("dec_rand_mdop", {63'd0, md_op},
                  {63'd0, (ALUOp == 2'b10) && opb5 && funct7b0});
            @(negedge clk);
        end

        // Directed M ops from the specification examples.
        run_md(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
        run_md(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_md(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_md(3'd2, 32'hFFFF_FFFE, 32'h0000_0003, 0);
        run_md(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_md(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_md(3'd5, 32'd5, 32'd0, 0);
        run_md(3'd7, 32'd5, 32'd0, 0);
        run_md(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
        // Back-to-back: valid held across DONE, second op re-accepted from IDLE.
        run_md(3'd4, 32'hFFFF_FFF9, 32'd2, 1);
        run_md(3'd0, 32'd12345, 32'd678, 0);

        // Flush: valid drops mid-multiply; result still completes.
        run_md(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
        ALUOp = 2'b10; opb5 = 1'b1; funct7b0 = 1'b1; funct3 = 3'd0;
        srca = 32'd1000; srcb = 32'd77; valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        #1;
        check("flush_stall", {63'd0, stall}, 64'd0);
        n = 0;
        while (md_done !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        check("flush_done", {63'd0, md_done}, 64'd1);
        check("flush_result", {32'd0, md_result}, 64'd77000);
        @(negedge clk);

        // Reset 10 cycles into a divide aborts to reset values.
        run_md(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
        ALUOp = 2'b10; opb5 = 1'b1; funct7b0 = 1'b1; funct3 = 3'd5;
        srca = 32'd1000; srcb = 32'd7; valid_in = 1'b1;
        repeat (10) @(negedge clk);
        valid_in = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        #1;
        check("midrst_stall", {63'd0, stall}, 64'd0);
        check("midrst_done", {63'd0, md_done}, 64'd0);
        check("midrst_result", {32'd0, md_result}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        run_md(3'd5, 32'd1000, 32'd7, 0);

        // Randomized M ops with biased operand corners.
        for (int i = 0; i < 30; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: a = 32'($urandom_range(0, 100));
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: ;
            endcase
            run_md(f3, a, b, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
